// File: rtl/rf_cmd_seq_pkg.sv
// Shared opcode encodings and FSM state type for the register-file command sequencer.
package rf_cmd_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_GET = 4'd2;
  localparam logic [3:0] OP_ACC = 4'd3;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IMM  = 3'd1,
    S_ARG  = 3'd2,
    S_RD_A = 3'd3,
    S_RD_B = 3'd4,
    S_CAP  = 3'd5,
    S_WB   = 3'd6,
    S_RSP  = 3'd7
  } state_e;

endpackage

// File: rtl/rf_cmd_seq_alu.sv
// DW-bit adder for the ACC command; saturates on carry-out when RF_CMD_SEQ_SAT_EN
// is defined, otherwise wraps modulo 2^DW.
module rf_cmd_seq_alu
  import rf_cmd_seq_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  output logic [DW-1:0] sum_o
);

`ifdef RF_CMD_SEQ_SAT_EN
  logic [DW:0] full_s;

  // Widened add, clamp to all-ones when the carry is set.
  always_comb begin
    full_s = {1'b0, a_i} + {1'b0, b_i};
    if (full_s[DW]) begin
      sum_o = {DW{1'b1}};
    end else begin
      sum_o = full_s[DW-1:0];
    end
  end
`else
  // Plain modular add.
  always_comb begin
    sum_o = a_i + b_i;
  end
`endif

endmodule

// File: rtl/rf_cmd_seq.sv
// Byte-stream command sequencer driving one read and one write port of the register file.
// Build option: RF_CMD_SEQ_SAT_EN selects a saturating ACC result.
module rf_cmd_seq
  import rf_cmd_seq_pkg::*;
#(
  parameter  int NREGS = 16,
  parameter  int DW    = 8,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rf_re,
  output logic [AW-1:0] rf_raddr,
  input  logic [DW-1:0] rf_rdata,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          busy,
  output logic          err
);

  state_e        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [DW-1:0] a_q, a_d;
  logic          acc_q, acc_d;
  logic          err_q, err_d;
  logic          cmd_ready_q, cmd_ready_d;
  logic          busy_q, busy_d;
  logic          rf_re_q, rf_re_d;
  logic [AW-1:0] rf_raddr_q, rf_raddr_d;
  logic          rf_we_q, rf_we_d;
  logic [AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DW-1:0] rf_wdata_q, rf_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;
  logic          cmd_fire_s;
  logic [DW-1:0] sum_s;

  assign cmd_fire_s = cmd_valid && cmd_ready_q;

  rf_cmd_seq_alu #(.DW(DW)) u_alu (
    .a_i   (a_q),
    .b_i   (rf_rdata),
    .sum_o (sum_s)
  );

  // Next-state and next-output decode; strobes are computed from the state being
  // entered so that the registered pulse lines up with that state.
  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    a_d         = a_q;
    acc_d       = acc_q;
    err_d       = err_q;
    rf_re_d     = 1'b0;
    rf_raddr_d  = rf_raddr_q;
    rf_we_d     = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire_s) begin
          src_d = cmd_data[4 +: AW];
          case (cmd_data[3:0])
            OP_NOP: state_d = S_IDLE;
            OP_MOV: state_d = S_IMM;
            OP_GET: begin
              acc_d      = 1'b0;
              rf_re_d    = 1'b1;
              rf_raddr_d = cmd_data[4 +: AW];
              state_d    = S_RD_A;
            end
            OP_ACC: begin
              acc_d   = 1'b1;
              state_d = S_ARG;
            end
            default: err_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IMM: begin
        if (cmd_fire_s) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = src_q;
          rf_wdata_d = cmd_data;
          state_d    = S_WB;
        end else begin
          state_d = S_IMM;
        end
      end
      S_ARG: begin
        if (cmd_fire_s) begin
          dst_d      = cmd_data[AW-1:0];
          rf_re_d    = 1'b1;
          rf_raddr_d = src_q;
          state_d    = S_RD_A;
        end else begin
          state_d = S_ARG;
        end
      end
      S_RD_A: begin
        if (acc_q) begin
          rf_re_d    = 1'b1;
          rf_raddr_d = dst_q;
          state_d    = S_RD_B;
        end else begin
          state_d = S_CAP;
        end
      end
      S_RD_B: begin
        a_d     = rf_rdata;
        state_d = S_CAP;
      end
      S_CAP: begin
        if (acc_q) begin
          rf_we_d    = 1'b1;
          rf_waddr_d = dst_q;
          rf_wdata_d = sum_s;
          state_d    = S_WB;
        end else begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rf_rdata;
          state_d     = S_RSP;
        end
      end
      S_WB: state_d = S_IDLE;
      S_RSP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    cmd_ready_d = (state_d == S_IDLE) || (state_d == S_IMM) || (state_d == S_ARG);
    busy_d      = (state_d != S_IDLE);
  end

  // State, operand and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      src_q       <= {AW{1'b0}};
      dst_q       <= {AW{1'b0}};
      a_q         <= {DW{1'b0}};
      acc_q       <= 1'b0;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rf_re_q     <= 1'b0;
      rf_raddr_q  <= {AW{1'b0}};
      rf_we_q     <= 1'b0;
      rf_waddr_q  <= {AW{1'b0}};
      rf_wdata_q  <= {DW{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= {DW{1'b0}};
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      a_q         <= a_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rf_re_q     <= rf_re_d;
      rf_raddr_q  <= rf_raddr_d;
      rf_we_q     <= rf_we_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign rf_re     = rf_re_q;
  assign rf_raddr  = rf_raddr_q;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rf_cmd_seq.sv
// Self-checking bench for rf_cmd_seq: cycle-accurate directed sequences, a vector
// table, and randomized commands against a behavioural register-file model.
module tb_rf_cmd_seq;

`ifdef RF_CMD_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rf_re;
  logic [3:0] rf_raddr;
  logic [7:0] rf_rdata;
  logic       rf_we;
  logic [3:0] rf_waddr;
  logic [7:0] rf_wdata;
  logic       busy;
  logic       err;

  always #5 clk = ~clk;

  rf_cmd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rf_re     (rf_re),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy),
    .err       (err)
  );

  // Register file environment (1-cycle read latency) plus event monitors.
  logic [7:0] mem [16];
  logic [7:0] rsp_log [1024];
  int         we_cnt  = 0;
  int         re_cnt  = 0;
  int         rsp_cnt = 0;
  logic [3:0] last_waddr = 4'h0;
  logic [7:0] last_wdata = 8'h00;
  logic       both_hi = 1'b0;

  always @(posedge clk) begin
    if (rf_we) begin
      mem[rf_waddr] <= rf_wdata;
      we_cnt        <= we_cnt + 1;
      last_waddr    <= rf_waddr;
      last_wdata    <= rf_wdata;
    end
    if (rf_re) begin
      rf_rdata <= mem[rf_raddr];
      re_cnt   <= re_cnt + 1;
    end
    if (rf_re && rf_we) both_hi <= 1'b1;
    if (rsp_valid && rsp_ready) begin
      rsp_log[rsp_cnt % 1024] <= rsp_data;
      rsp_cnt                 <= rsp_cnt + 1;
    end
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present one byte and return at the negedge following its accept edge.
  task automatic put_byte(input logic [7:0] b);
    bit done = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 64 && !done; i++) begin
      if (cmd_ready) done = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    chk("byte_accept", 32'(done), 32'd1);
  endtask

  // Issue a whole command and wait (bounded) until the sequencer is idle again.
  task automatic exec_cmd(input logic [7:0] b0, input logic [7:0] b1, input bit two, input bit rnd);
    bit done = 1'b0;
    put_byte(b0);
    if (two) begin
      if (rnd) repeat ($urandom_range(0, 3)) tick();
      put_byte(b1);
    end
    for (int i = 0; i < 64 && !done; i++) begin
      if (cmd_ready && !busy) begin
        done = 1'b1;
      end else begin
        rsp_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        tick();
      end
    end
    chk("cmd_complete", 32'(done), 32'd1);
  endtask

  function automatic logic [7:0] acc_ref(input logic [7:0] d, input logic [7:0] s);
    int t;
    t = int'(d) + int'(s);
    if (SAT && t > 255) return 8'hFF;
    return 8'(t % 256);
  endfunction

  typedef struct {
    logic [7:0] b0;
    logic [7:0] b1;
    bit         two;
    int         n_wr;
    logic [3:0] waddr;
    logic [7:0] wdata;
    int         n_re;
    int         n_rsp;
    logic [7:0] rsp;
    logic       err;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] acc_exp;
  logic [7:0] ref_rf [16];
  logic       ref_err;
  int         w0, r0, p0, rd_idx, k;
  logic [3:0] op, rr;
  logic [7:0] b1, v;

  initial begin
    acc_exp = SAT ? 8'hFF : 8'h10;
    tbl[0]  = '{8'h11, 8'hF0, 1'b1, 1, 4'h1, 8'hF0, 0, 0, 8'h00, 1'b0};
    tbl[1]  = '{8'h21, 8'h20, 1'b1, 1, 4'h2, 8'h20, 0, 0, 8'h00, 1'b0};
    tbl[2]  = '{8'h13, 8'h02, 1'b1, 1, 4'h2, acc_exp, 2, 0, 8'h00, 1'b0};
    tbl[3]  = '{8'h22, 8'h00, 1'b0, 0, 4'h0, 8'h00, 1, 1, acc_exp, 1'b0};
    tbl[4]  = '{8'h31, 8'h41, 1'b1, 1, 4'h3, 8'h41, 0, 0, 8'h00, 1'b0};
    tbl[5]  = '{8'h33, 8'h03, 1'b1, 1, 4'h3, 8'h82, 2, 0, 8'h00, 1'b0};
    tbl[6]  = '{8'h32, 8'h00, 1'b0, 0, 4'h0, 8'h00, 1, 1, 8'h82, 1'b0};
    tbl[7]  = '{8'h70, 8'h00, 1'b0, 0, 4'h0, 8'h00, 0, 0, 8'h00, 1'b0};
    tbl[8]  = '{8'h0F, 8'h00, 1'b0, 0, 4'h0, 8'h00, 0, 0, 8'h00, 1'b1};
    tbl[9]  = '{8'h61, 8'h5A, 1'b1, 1, 4'h6, 8'h5A, 0, 0, 8'h00, 1'b1};
    tbl[10] = '{8'h62, 8'h00, 1'b0, 0, 4'h0, 8'h00, 1, 1, 8'h5A, 1'b1};
    tbl[11] = '{8'hF4, 8'h00, 1'b0, 0, 4'h0, 8'h00, 0, 0, 8'h00, 1'b1};
    tbl[12] = '{8'h52, 8'h00, 1'b0, 0, 4'h0, 8'h00, 1, 1, 8'hA7, 1'b1};

    // Reset values and first ready cycle.
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_data = 8'h00; rsp_ready = 1'b0;
    repeat (3) tick();
    chk("reset_outs", 32'({cmd_ready, rsp_valid, rsp_data, rf_re, rf_raddr, rf_we,
                          rf_waddr, rf_wdata, busy, err}), 32'd0);
    rst_n = 1'b1;
    chk("ready_before_edge", 32'(cmd_ready), 32'd0);
    tick();
    chk("ready_after_release", 32'(cmd_ready), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd0);

    // MOV r5 <- 0xA7 with a pause between bytes.
    rsp_ready = 1'b1;
    put_byte(8'h51);
    chk("mov_imm_ready", 32'(cmd_ready), 32'd1);
    chk("mov_imm_busy", 32'(busy), 32'd1);
    repeat (3) tick();
    chk("mov_hold_ready", 32'(cmd_ready), 32'd1);
    chk("mov_hold_we", 32'(rf_we), 32'd0);
    put_byte(8'hA7);
    chk("mov_we", 32'({rf_we, rf_re, rf_waddr, rf_wdata}), 32'({1'b1, 1'b0, 4'h5, 8'hA7}));
    tick();
    chk("mov_we_pulse", 32'(rf_we), 32'd0);
    chk("mov_ready_again", 32'(cmd_ready), 32'd1);
    chk("mov_err", 32'(err), 32'd0);

    // GET r5 with the consumer stalled for five cycles.
    rsp_ready = 1'b0;
    put_byte(8'h52);
    chk("get_re", 32'({rf_re, rf_raddr, rsp_valid}), 32'({1'b1, 4'h5, 1'b0}));
    tick();
    chk("get_cap", 32'({rf_re, rsp_valid}), 32'd0);
    tick();
    chk("get_rsp", 32'({rsp_valid, rsp_data}), 32'({1'b1, 8'hA7}));
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("get_stall", 32'({rsp_valid, rsp_data, cmd_ready}), 32'({1'b1, 8'hA7, 1'b0}));
    end
    rsp_ready = 1'b1;
    tick();
    chk("get_release", 32'({rsp_valid, cmd_ready}), 32'({1'b0, 1'b1}));

    // ACC r2 += r1 with wrap/saturate, cycle by cycle.
    exec_cmd(8'h11, 8'hF0, 1'b1, 1'b0);
    exec_cmd(8'h21, 8'h20, 1'b1, 1'b0);
    put_byte(8'h13);
    put_byte(8'h02);
    chk("acc_u1", 32'({rf_re, rf_raddr, rf_we}), 32'({1'b1, 4'h1, 1'b0}));
    tick();
    chk("acc_u2", 32'({rf_re, rf_raddr, rf_we}), 32'({1'b1, 4'h2, 1'b0}));
    tick();
    chk("acc_u3", 32'({rf_re, rf_we, busy}), 32'({1'b0, 1'b0, 1'b1}));
    tick();
    chk("acc_u4", 32'({rf_we, rf_re, rf_waddr, rf_wdata}), 32'({1'b1, 1'b0, 4'h2, acc_exp}));
    tick();
    chk("acc_u5", 32'({cmd_ready, rf_we, busy}), 32'({1'b1, 1'b0, 1'b0}));

    // Vector table.
    for (int i = 0; i < 13; i++) begin
      w0 = we_cnt; r0 = re_cnt; p0 = rsp_cnt;
      exec_cmd(tbl[i].b0, tbl[i].b1, tbl[i].two, 1'b0);
      chk($sformatf("tbl%0d_nwr", i), 32'(we_cnt - w0), 32'(tbl[i].n_wr));
      chk($sformatf("tbl%0d_nre", i), 32'(re_cnt - r0), 32'(tbl[i].n_re));
      chk($sformatf("tbl%0d_nrsp", i), 32'(rsp_cnt - p0), 32'(tbl[i].n_rsp));
      if (tbl[i].n_wr > 0)
        chk($sformatf("tbl%0d_write", i), 32'({last_waddr, last_wdata}),
            32'({tbl[i].waddr, tbl[i].wdata}));
      if (tbl[i].n_rsp > 0)
        chk($sformatf("tbl%0d_rsp", i), 32'(rsp_log[(rsp_cnt - 1) % 1024]), 32'(tbl[i].rsp));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
    end

    // Reset in the middle of an ACC (U+2): drop it, no write.
    put_byte(8'h13);
    put_byte(8'h02);
    tick();
    w0 = we_cnt;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outs", 32'({cmd_ready, rsp_valid, rsp_data, rf_re, rf_raddr, rf_we,
                              rf_waddr, rf_wdata, busy, err}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 32'({cmd_ready, busy, err}), 32'({1'b1, 1'b0, 1'b0}));
    repeat (3) tick();
    chk("rst_no_write", 32'(we_cnt - w0), 32'd0);

    // Randomized commands against the behavioural model.
    ref_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = 8'($urandom);
      exec_cmd({4'(i), 4'h1}, v, 1'b1, 1'b1);
      ref_rf[i] = v;
    end
    rd_idx = rsp_cnt;
    for (int n = 0; n < 250; n++) begin
      k  = $urandom_range(0, 9);
      rr = 4'($urandom_range(0, 15));
      b1 = 8'($urandom);
      if (k == 0)      op = 4'h0;
      else if (k <= 3) op = 4'h1;
      else if (k <= 6) op = 4'h2;
      else if (k <= 8) op = 4'h3;
      else             op = 4'($urandom_range(4, 15));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      exec_cmd({rr, op}, b1, (op == 4'h1) || (op == 4'h3), 1'b1);
      case (op)
        4'h0: ;
        4'h1: ref_rf[rr] = b1;
        4'h2: begin
          chk("rand_rsp_cnt", 32'(rsp_cnt), 32'(rd_idx + 1));
          chk("rand_rsp_data", 32'(rsp_log[rd_idx % 1024]), 32'(ref_rf[rr]));
          rd_idx++;
        end
        4'h3: ref_rf[b1[3:0]] = acc_ref(ref_rf[b1[3:0]], ref_rf[rr]);
        default: ref_err = 1'b1;
      endcase
    end
    for (int i = 0; i < 16; i++)
      chk($sformatf("rand_rf%0d", i), 32'(mem[i]), 32'(ref_rf[i]));
    chk("rand_err", 32'(err), 32'(ref_err));
    chk("re_we_exclusive", 32'(both_hi), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rf_cmd_seq.md
# rf_cmd_seq

Byte-stream command sequencer for the 16 x 8 register file. Accepts opcode/operand bytes from the input pins over a valid/ready handshake, decodes them, and drives the register file's single read port and single write port with correctly ordered, registered strobes. Returns read data over a response handshake, so the top level only wires pins to this block and the register file.

## Interface
Parameters:
- NREGS, 16: register count; AW = $clog2(NREGS) = 4.
- DW, 8: data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command byte valid.
- cmd_ready  out  1  byte accepted when valid & ready.
- cmd_data  in  DW  command byte.
- rsp_valid  out  1  response data valid; held until accepted.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DW  read result.
- rf_re  out  1  read strobe; rf_rdata valid the following cycle.
- rf_raddr  out  AW  read address.
- rf_rdata  in  DW  read data, 1-cycle latency after rf_re.
- rf_we  out  1  write strobe.
- rf_waddr  out  AW  write address.
- rf_wdata  out  DW  write data.
- busy  out  1  high in any state other than IDLE.
- err  out  1  sticky illegal-opcode flag.

## Operation
- Opcode is cmd_data[3:0]; operand R = cmd_data[7:4].
  - 0 NOP: consumed, no effect.
  - 1 MOV: second byte is the immediate; rf[R] <= imm.
  - 2 GET: rsp_data <= rf[R].
  - 3 ACC: second byte bits[3:0] = D; rf[D] <= rf[D] + rf[R].
  - 4..15: consumed, err set, no register-file access.
- States: IDLE, IMM (await MOV immediate), ARG (await ACC dst), RD_A, RD_B, CAP, WB, RSP.
- cmd_ready = 1 only in IDLE, IMM and ARG.
- All rf_* and rsp_* outputs are registered.
- ACC with R == D doubles the register; sequencing is unchanged.
- Sum wraps modulo 2^DW; with saturation compiled in, see Configuration.
- RSP holds rsp_data stable while rsp_valid=1 && rsp_ready=0.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_data=0, rf_re=0, rf_we=0, all addresses and wdata 0, busy=0, err=0. State goes to IDLE. cmd_ready rises the first cycle after reset release.
- Reset mid-operation: any pending command or response is dropped. Register-file contents are not this block's responsibility.
- err clears only on reset.

## Timing
T is the accept edge of the opcode byte; U is the accept edge of the second byte.
- MOV: U+1 rf_we=1 with waddr=R and wdata=imm (WB); cmd_ready=1 again at U+2.
- GET: T+1 rf_re=1 with raddr=R (RD_A); T+2 capture rf_rdata (CAP); T+3 rsp_valid=1 (RSP); leaves RSP on the rsp_valid & rsp_ready edge, cmd_ready=1 the next cycle.
- ACC: U+1 rf_re with raddr=R; U+2 rf_re with raddr=D and capture A; U+3 capture B; U+4 rf_we with waddr=D and wdata=A+B; cmd_ready=1 at U+5.
- rf_re and rf_we are single-cycle pulses and are never high together.
- Between bytes of a two-byte command, cmd_valid may stay low indefinitely; state holds in IMM or ARG.

## Configuration
- RF_CMD_SEQ_SAT_EN defined: ACC result saturates to 2^DW-1 on carry-out.
- Undefined: ACC result is (A+B) mod 2^DW.
- No other behaviour or timing differs.

## Structure
- Package rf_cmd_seq_pkg holds the opcode localparams (OP_NOP, OP_MOV, OP_GET, OP_ACC) and the state enum typedef.
- One sub-module, rf_cmd_seq_alu: combinational DW-bit add with optional saturation, gated by the macro.
- FSM, operand registers and handshakes stay in rf_cmd_seq.

## Test plan
- Reset, then MOV: bytes 0x51, 0xA7 -> one-cycle rf_we with waddr=5, wdata=0xA7 at U+1; err=0.
- GET after that MOV: byte 0x52 -> rf_re with raddr=5 at T+1; rsp_valid with rsp_data=0xA7 at T+3. With rsp_ready held low 5 cycles, data stays stable and cmd_ready stays 0.
- ACC with wrap: rf[1]=0xF0, rf[2]=0x20; bytes 0x13, 0x02 -> rf_wdata=0x10 at U+4, or 0xFF with RF_CMD_SEQ_SAT_EN.
- ACC with R == D: rf[3]=0x41; bytes 0x33, 0x03 -> rf_wdata=0x82.
- Illegal opcode 0x0F -> byte consumed, err=1 persists, no rf_re or rf_we. A following MOV still executes.
- Reset asserted at ACC U+2 -> all outputs 0 asynchronously, no rf_we. After release, cmd_ready=1 in IDLE.
